approx_add_err_monitor: RTL and testbench

- Streaming error-characterisation stage directly downstream of a 16-bit approximate unsigned adder.
- Per accepted sample, it takes the adder operands and the approximate sum, recomputes the exact sum, and accumulates:
  - sum of absolute error (MAE numerator)
  - worst-case error (WCE)
  - count of erroneous samples (EP numerator)
- Runs over a fixed batch of 2^SAMPLE_LOG2 samples, then holds the results for readout by the FPGA power/accuracy harness.

---
 rtl/approx_add_err_monitor.sv | 271 +++++++++++++++++++++++++++
 tb/tb_approx_add_err_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_err_monitor.sv
// approx_add_err_monitor
// Error-characterisation stage placed after a W-bit approximate unsigned adder.
// For each accepted sample it recomputes the exact sum and, over a batch of
// 2^SAMPLE_LOG2 samples, accumulates the absolute-error sum (saturating), the
// worst-case error and the number of erroneous samples. Results are held in
// DONE until the next start pulse.
// Two-stage pipeline: S1 = exact sum, S2 = |exact - approx|; the statistics
// registers update on the edge after S2, so results are final 2 cycles after
// the last accept.
// Optional build macro APPROX_ERR_MSE_EN adds the sq_sum port accumulating d*d.
module approx_add_err_monitor #(
  parameter int W           = 16,
  parameter int SAMPLE_LOG2 = 16,
  parameter int ACC_W       = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           a,
  input  logic [W-1:0]           b,
  input  logic [W:0]             o_approx,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W-1:0]       err_sum,
  output logic [W:0]             wce,
  output logic [SAMPLE_LOG2:0]   err_cnt,
  output logic [SAMPLE_LOG2:0]   sample_cnt
`ifdef APPROX_ERR_MSE_EN
  ,
  output logic [2*(W+1)+SAMPLE_LOG2-1:0] sq_sum
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index of the last sample of a batch (2^SAMPLE_LOG2 - 1).
  localparam logic [SAMPLE_LOG2:0] BATCH_M1 = {1'b0, {SAMPLE_LOG2{1'b1}}};
  localparam logic [SAMPLE_LOG2:0] CNT_ONE  = {{SAMPLE_LOG2{1'b0}}, 1'b1};

`ifdef APPROX_ERR_MSE_EN
  localparam int SQ_W = 2*(W+1);
  localparam int SQ_ACC_W = SQ_W + SAMPLE_LOG2;
`endif

  // Unsigned magnitude of the difference: larger operand minus smaller one.
  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    logic [W:0] r;
    if (x >= y) begin
      r = x - y;
    end else begin
      r = y - x;
    end
    return r;
  endfunction

  state_t                 state_q, state_d;
  logic                   drain_cnt_q, drain_cnt_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   s1_valid_q, s1_valid_d;
  logic [W:0]             s1_exact_q, s1_exact_d;
  logic [W:0]             s1_approx_q, s1_approx_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [W:0]             s2_d_q, s2_d_d;

  logic [ACC_W-1:0]       err_sum_q, err_sum_d;
  logic [W:0]             wce_q, wce_d;
  logic [SAMPLE_LOG2:0]   err_cnt_q, err_cnt_d;
  logic [SAMPLE_LOG2:0]   sample_cnt_q, sample_cnt_d;

  logic                   accept_s;
  logic                   last_s;
  logic                   clear_s;
  logic [W:0]             mag_s;
  logic [ACC_W:0]         sum_ext_s;

`ifdef APPROX_ERR_MSE_EN
  logic [SQ_W-1:0]        s2_sq_q, s2_sq_d;
  logic [SQ_ACC_W-1:0]    sq_sum_q, sq_sum_d;
`endif

  assign accept_s  = in_valid && (state_q == ST_RUN);
  assign last_s    = accept_s && (sample_cnt_q == BATCH_M1);
  assign mag_s     = abs_diff(s1_exact_q, s1_approx_q);
  assign sum_ext_s = {1'b0, err_sum_q} + {{(ACC_W-W){1'b0}}, s2_d_q};

  // Next-state logic of the batch FSM and the decoded status outputs.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    clear_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clear_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Two cycles let the final sample travel through S1 and S2.
        if (drain_cnt_q) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clear_s = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    in_ready_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d     = (state_d == ST_DONE);
  end

  // Pipeline stages: S1 captures the exact sum, S2 the error magnitude.
  always_comb begin
    s1_valid_d  = accept_s;
    s2_valid_d  = s1_valid_q;
    if (accept_s) begin
      s1_exact_d  = {1'b0, a} + {1'b0, b};
      s1_approx_d = o_approx;
    end else begin
      s1_exact_d  = s1_exact_q;
      s1_approx_d = s1_approx_q;
    end
    if (s1_valid_q) begin
      s2_d_d = mag_s;
    end else begin
      s2_d_d = s2_d_q;
    end
`ifdef APPROX_ERR_MSE_EN
    if (s1_valid_q) begin
      s2_sq_d = {{(W+1){1'b0}}, mag_s} * {{(W+1){1'b0}}, mag_s};
    end else begin
      s2_sq_d = s2_sq_q;
    end
`endif
  end

  // Batch statistics: cleared on entering RUN, updated from a valid S2.
  always_comb begin
    err_sum_d    = err_sum_q;
    wce_d        = wce_q;
    err_cnt_d    = err_cnt_q;
    sample_cnt_d = sample_cnt_q;
`ifdef APPROX_ERR_MSE_EN
    sq_sum_d     = sq_sum_q;
`endif
    if (clear_s) begin
      err_sum_d    = {ACC_W{1'b0}};
      wce_d        = {(W+1){1'b0}};
      err_cnt_d    = {(SAMPLE_LOG2+1){1'b0}};
      sample_cnt_d = {(SAMPLE_LOG2+1){1'b0}};
`ifdef APPROX_ERR_MSE_EN
      sq_sum_d     = {SQ_ACC_W{1'b0}};
`endif
    end else begin
      if (accept_s) begin
        sample_cnt_d = sample_cnt_q + CNT_ONE;
      end else begin
        sample_cnt_d = sample_cnt_q;
      end
      if (s2_valid_q) begin
        // Saturation only matters when ACC_W is shrunk below its safe size.
        if (sum_ext_s[ACC_W]) begin
          err_sum_d = {ACC_W{1'b1}};
        end else begin
          err_sum_d = sum_ext_s[ACC_W-1:0];
        end
        if (s2_d_q > wce_q) begin
          wce_d = s2_d_q;
        end else begin
          wce_d = wce_q;
        end
        if (s2_d_q != {(W+1){1'b0}}) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
          err_cnt_d = err_cnt_q;
        end
`ifdef APPROX_ERR_MSE_EN
        sq_sum_d = sq_sum_q + {{SAMPLE_LOG2{1'b0}}, s2_sq_q};
`endif
      end else begin
        err_sum_d = err_sum_q;
      end
    end
  end

  // State, pipeline and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_exact_q   <= {(W+1){1'b0}};
      s1_approx_q  <= {(W+1){1'b0}};
      s2_valid_q   <= 1'b0;
      s2_d_q       <= {(W+1){1'b0}};
      err_sum_q    <= {ACC_W{1'b0}};
      wce_q        <= {(W+1){1'b0}};
      err_cnt_q    <= {(SAMPLE_LOG2+1){1'b0}};
      sample_cnt_q <= {(SAMPLE_LOG2+1){1'b0}};
`ifdef APPROX_ERR_MSE_EN
      s2_sq_q      <= {SQ_W{1'b0}};
      sq_sum_q     <= {SQ_ACC_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      s1_valid_q   <= s1_valid_d;
      s1_exact_q   <= s1_exact_d;
      s1_approx_q  <= s1_approx_d;
      s2_valid_q   <= s2_valid_d;
      s2_d_q       <= s2_d_d;
      err_sum_q    <= err_sum_d;
      wce_q        <= wce_d;
      err_cnt_q    <= err_cnt_d;
      sample_cnt_q <= sample_cnt_d;
`ifdef APPROX_ERR_MSE_EN
      s2_sq_q      <= s2_sq_d;
      sq_sum_q     <= sq_sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_sum    = err_sum_q;
  assign wce        = wce_q;
  assign err_cnt    = err_cnt_q;
  assign sample_cnt = sample_cnt_q;
`ifdef APPROX_ERR_MSE_EN
  assign sq_sum     = sq_sum_q;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Self-checking bench for approx_add_err_monitor (batch of 4 samples).
// Expected statistics come from a plain-arithmetic model over the accepted
// samples of each batch.
module tb_approx_add_err_monitor;

  localparam int W     = 16;
  localparam int SL    = 2;
  localparam int ACC_W = 40;
  localparam int N     = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    a = '0;
  logic [W-1:0]    b = '0;
  logic [W:0]      o_approx = '0;
  logic            busy;
  logic            done;
  logic [ACC_W-1:0] err_sum;
  logic [W:0]      wce;
  logic [SL:0]     err_cnt;
  logic [SL:0]     sample_cnt;
`ifdef APPROX_ERR_MSE_EN
  logic [2*(W+1)+SL-1:0] sq_sum;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  longint exp_sum, exp_wce, exp_cnt, exp_sq;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W:0]   qo[$];
  bit           qv[$];

  approx_add_err_monitor #(.W(W), .SAMPLE_LOG2(SL), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .a(a), .b(b), .o_approx(o_approx),
    .busy(busy), .done(done), .err_sum(err_sum), .wce(wce),
    .err_cnt(err_cnt), .sample_cnt(sample_cnt)
`ifdef APPROX_ERR_MSE_EN
    , .sq_sum(sq_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_sum = 0; exp_wce = 0; exp_cnt = 0; exp_sq = 0;
  endtask

  task automatic model_add(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic [W:0] o_);
    longint e, o, d;
    e = longint'(a_) + longint'(b_);
    o = longint'(o_);
    d = (e >= o) ? e - o : o - e;
    exp_sum += d;
    if (d > exp_wce) exp_wce = d;
    if (d != 0) exp_cnt++;
    exp_sq += d * d;
  endtask

  task automatic push(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic [W:0] o_);
    qa.push_back(a_); qb.push_back(b_); qo.push_back(o_);
  endtask

  task automatic clear_q();
    qa.delete(); qb.delete(); qo.delete(); qv.delete();
  endtask

  task automatic gen_random();
    logic [W-1:0] ra, rb;
    longint e, t;
    clear_q();
    for (int i = 0; i < N; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      e  = longint'(ra) + longint'(rb);
      case ($urandom_range(0, 3))
        0:       t = e;
        1:       t = e + longint'($urandom_range(1, 300));
        2:       t = e - longint'($urandom_range(1, 300));
        default: t = longint'($urandom_range(0, 131071));
      endcase
      t = t & 64'h1FFFF;
      push(ra, rb, t[W:0]);
    end
  endtask

  task automatic check_stats(input string tag, input int exp_n);
    check_eq({tag, ".err_sum"}, err_sum, exp_sum);
    check_eq({tag, ".wce"}, wce, exp_wce);
    check_eq({tag, ".err_cnt"}, err_cnt, exp_cnt);
    check_eq({tag, ".sample_cnt"}, sample_cnt, exp_n);
`ifdef APPROX_ERR_MSE_EN
    check_eq({tag, ".sq_sum"}, sq_sum, exp_sq);
`endif
  endtask

  // Called just after a posedge; returns just after a posedge, now in RUN.
  task automatic do_start(input bit with_valid);
    start = 1'b1; in_valid = with_valid;
    a = W'($urandom); b = W'($urandom); o_approx = (W+1)'($urandom);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    model_reset();
    check_eq("start.busy", busy, 1);
    check_eq("start.done", done, 0);
    check_eq("start.in_ready", in_ready, 1);
    check_stats("start", 0);
    @(posedge clk); #1;
  endtask

  // Streams qa/qb/qo; valid pattern from qv, random once qv is exhausted.
  task automatic feed(input string tag, input bit mid_start, output int cycles);
    int acc = 0;
    int cyc = 0;
    bit v, go;
    while (acc < N && cyc < 200) begin
      v = (cyc < qv.size()) ? qv[cyc] : ($urandom_range(0, 3) != 0);
      cyc++;
      in_valid = v; a = qa[acc]; b = qb[acc]; o_approx = qo[acc];
      start = mid_start && (acc == 2);
      @(negedge clk);
      check_eq({tag, ".run_ready"}, in_ready, 1);
      check_eq({tag, ".run_cnt"}, sample_cnt, acc);
      go = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (go) begin
        model_add(qa[acc], qb[acc], qo[acc]);
        acc++;
      end
    end
    cycles = cyc;
    check_eq({tag, ".accepts"}, acc, N);
    // Stray valid pulses after the last accept must be ignored.
    in_valid = 1'b1; a = W'($urandom); b = W'($urandom); o_approx = (W+1)'($urandom);
    @(negedge clk);
    check_eq({tag, ".drain_ready"}, in_ready, 0);
    check_eq({tag, ".drain_busy"}, busy, 1);
    check_eq({tag, ".drain_done0"}, done, 0);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    check_eq({tag, ".drain_done1"}, done, 0);
    check_eq({tag, ".drain_ready1"}, in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".done_busy"}, busy, 0);
    check_stats({tag, ".final"}, N);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_eq({tag, ".hold_ready"}, in_ready, 0);
      check_eq({tag, ".hold_done"}, done, 1);
    end
    check_stats({tag, ".hold"}, N);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".in_ready"}, in_ready, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".err_sum"}, err_sum, 0);
    check_eq({tag, ".wce"}, wce, 0);
    check_eq({tag, ".err_cnt"}, err_cnt, 0);
    check_eq({tag, ".sample_cnt"}, sample_cnt, 0);
`ifdef APPROX_ERR_MSE_EN
    check_eq({tag, ".sq_sum"}, sq_sum, 0);
`endif
  endtask

  initial begin
    int cyc;
    #12;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // IDLE ignores valid samples.
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("idle.in_ready", in_ready, 0);
    check_eq("idle.sample_cnt", sample_cnt, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Exact stream.
    do_start(1'b1);
    clear_q();
    push(16'h1234, 16'h0F0F, 17'h02143);
    push(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    push(16'h0000, 16'h0000, 17'h00000);
    push(16'h8000, 16'h8001, 17'h10001);
    feed("exact", 1'b0, cyc);
    check_eq("exact.fix_sum", err_sum, 0);
    check_eq("exact.fix_wce", wce, 0);
    check_eq("exact.fix_cnt", err_cnt, 0);

    // Constant bias; start from DONE also verifies clearing.
    do_start(1'b1);
    clear_q();
    repeat (N) push(16'h0000, 16'h0000, 17'h00008);
    feed("bias", 1'b0, cyc);
    check_eq("bias.fix_sum", err_sum, 32);
    check_eq("bias.fix_wce", wce, 8);
    check_eq("bias.fix_cnt", err_cnt, 4);
`ifdef APPROX_ERR_MSE_EN
    check_eq("bias.fix_sq", sq_sum, 256);
`endif

    // Both error signs.
    do_start(1'b0);
    clear_q();
    push(16'hFFFF, 16'hFFFF, 17'h1FFCC);
    push(16'h0010, 16'h0000, 17'h00000);
    push(16'h0001, 16'h0002, 17'h00003);
    push(16'hABCD, 16'h1111, 17'h0BCDE);
    feed("signs", 1'b0, cyc);
    check_eq("signs.fix_sum", err_sum, 66);
    check_eq("signs.fix_wce", wce, 50);
    check_eq("signs.fix_cnt", err_cnt, 2);

    // Handshake gaps plus an ignored start during RUN.
    do_start(1'b1);
    gen_random();
    qv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    feed("gaps", 1'b1, cyc);
    check_eq("gaps.cycles", cyc, 7);
    qv.delete();

    // Random batches.
    for (int k = 0; k < 20; k++) begin
      do_start(1'($urandom_range(0, 1)));
      gen_random();
      feed("rand", 1'($urandom_range(0, 1)), cyc);
    end

    // Asynchronous reset mid-batch.
    do_start(1'b0);
    in_valid = 1'b1; a = 16'h0100; b = 16'h0200; o_approx = 17'h00000;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("areset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst.in_ready", in_ready, 0);
      check_eq("post_rst.busy", busy, 0);
      check_eq("post_rst.sample_cnt", sample_cnt, 0);
      @(posedge clk); #1;
    end
    do_start(1'b1);
    gen_random();
    feed("post_rst", 1'b0, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
